// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state type, baud derivation and frame lengths.
// UART_RX_PARITY_EN adds the PARITY state and one parity bit to the frame (8E1).
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

`ifdef UART_RX_PARITY_EN
  localparam int PARITY_BITS = 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} uart_state_t;
`else
  localparam int PARITY_BITS = 0;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} uart_state_t;
`endif

  // Start bit + data + optional parity + stop.
  localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_BITS + STOP_BITS;

  function automatic int baud_count(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int half_count(input int clk_freq, input int baud_rate);
    return baud_count(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops reset to RESET_VAL.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign dout = sync_q;

endmodule

// File: rtl/receiver.sv
// UART receiver, 8N1 LSB first, mid-bit sampling from a 16-bit baud counter.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err pulse output.
module receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int BAUD_COUNT = baud_count(CLK_FREQ, BAUD_RATE);
  localparam int HALF_COUNT = half_count(CLK_FREQ, BAUD_RATE);
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_COUNT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_COUNT - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

  if (BAUD_COUNT < 4) begin : g_baud_check
    $error("receiver: BAUD_COUNT must be at least 4");
  end

  uart_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        rxd_s;
`ifdef UART_RX_PARITY_EN
  logic        par_q, par_d;
  logic        parity_err_q, parity_err_d;
`endif

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (rxd),
    .dout  (rxd_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_out_d  = data_out_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxd_s) begin
          state_d   = START;
          bit_idx_d = '0;
        end
      end
      // Re-check the line at mid start bit to reject glitches.
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d     = '0;
          shift_d   = {rxd_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d   = '0;
          par_d   = rxd_s;
          state_d = STOP;
        end
      end
`endif
      // A low stop bit outranks a parity mismatch.
      STOP: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d = '0;
          if (!rxd_s) begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
          end else if ((^shift_q) != par_q) begin
            parity_err_d = 1'b1;
            state_d      = IDLE;
`endif
          end else begin
            data_out_d = shift_q;
            rx_valid_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_out_q  <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_out_q  <= data_out_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data_out  = data_out_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_receiver.sv
// Bench for receiver: serial frames driven bit by bit, a transaction-level model of
// expected pulses (kind, byte, arrival cycle) and directed literal checks.
module tb_receiver;
  import uart_pkg::*;

  localparam int B   = 1000000 / 9600;
  localparam int H   = B / 2;
  localparam int LAT = 2 + H + (FRAME_BITS - 1) * B;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  receiver dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .data_out  (data_out),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  // kind: 0 = good byte, 1 = frame error, 2 = parity error
  typedef struct {
    int         kind;
    logic [7:0] data;
    int         t0;
  } ev_t;

  ev_t        q[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_valid = 0;
  int         n_ferr = 0;
  int         n_perr = 0;
  int         last_lat = 0;
  logic [7:0] exp_data = 8'h00;
  logic       rst_at_edge = 1'b0;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= !reset;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d at cycle %0d", name, act, lo, hi, cyc);
    end
  endtask

  task automatic fail_event(input string name, input int act, input int exp);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
  endtask

  // Compare process: every cycle checks pulses against the expected-event queue.
  initial begin : cmp_proc
    ev_t e;
    int  np;
    int  obs;
    int  lat;
    forever begin
      @(negedge clk);
      np = int'(rx_valid) + int'(frame_err);
`ifdef UART_RX_PARITY_EN
      np = np + int'(parity_err);
`endif
      if (rst_at_edge) begin
        chk("reset_data_out", int'(data_out), 0);
        chk("reset_rx_valid", int'(rx_valid), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        chk("reset_busy", int'(busy), 0);
`ifdef UART_RX_PARITY_EN
        chk("reset_parity_err", int'(parity_err), 0);
`endif
        exp_data = 8'h00;
      end else begin
        if (np > 1) begin
          fail_event("pulse_exclusive", np, 1);
        end else if (np == 1) begin
          obs = rx_valid ? 0 : (frame_err ? 1 : 2);
          if (obs == 0) n_valid++;
          else if (obs == 1) n_ferr++;
          else n_perr++;
          if (q.size() == 0) begin
            fail_event("unexpected_pulse_kind", obs, -1);
          end else begin
            e   = q.pop_front();
            lat = cyc - e.t0;
            chk("pulse_kind", obs, e.kind);
            chk_range("pulse_latency", lat, LAT - 1, LAT + 1);
            last_lat = lat;
            if (e.kind == 0 && obs == 0) exp_data = e.data;
          end
        end
        if (q.size() > 0 && (cyc - q[0].t0) > LAT + 1) begin
          fail_event("missing_pulse_kind", -1, q[0].kind);
          void'(q.pop_front());
        end
        chk("data_out", int'(data_out), int'(exp_data));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (B) @(negedge clk);
  endtask

  // t0 is the first rising edge that sees the falling start edge.
  task automatic tx(input logic [7:0] b, input logic stop_bit, input logic bad_par);
    ev_t e;
    e.data = b;
    e.t0   = cyc + 1;
    e.kind = !stop_bit ? 1 : (bad_par ? 2 : 0);
    q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ bad_par);
`endif
    drive_bit(stop_bit);
  endtask

  initial begin : stim
    int         v0;
    int         f0;
    int         p0;
    int         t;
    logic [7:0] ab;
    @(negedge clk);
    reset = 1'b0;
    rxd   = 1'b1;
    idle(4);
    reset = 1'b1;
    idle(10);

    // Single byte 0xA5
    v0 = n_valid; f0 = n_ferr;
    tx(8'hA5, 1'b1, 1'b0);
    idle(20);
    chk("a5_valid_count", n_valid - v0, 1);
    chk("a5_ferr_count", n_ferr - f0, 0);
    chk("a5_data_out", int'(data_out), 8'hA5);
`ifdef UART_RX_PARITY_EN
    chk_range("a5_latency_literal", last_lat, 1093, 1095);
`else
    chk_range("a5_latency_literal", last_lat, 989, 991);
`endif

    // Back-to-back 0x00 then 0xFF, no idle gap
    v0 = n_valid;
    tx(8'h00, 1'b1, 1'b0);
    chk("b2b_first_data_out", int'(data_out), 8'h00);
    tx(8'hFF, 1'b1, 1'b0);
    idle(20);
    chk("b2b_valid_count", n_valid - v0, 2);
    chk("b2b_second_data_out", int'(data_out), 8'hFF);

    // Two more patterns back-to-back
    v0 = n_valid;
    tx(8'h01, 1'b1, 1'b0);
    tx(8'h80, 1'b1, 1'b0);
    idle(20);
    chk("pat_valid_count", n_valid - v0, 2);
    chk("pat_data_out", int'(data_out), 8'h80);

    // False start: 30 low cycles
    v0 = n_valid; f0 = n_ferr;
    rxd = 1'b0;
    t   = cyc;
    idle(30);
    rxd = 1'b1;
    idle(20);
    chk("false_start_busy_at_50", int'(busy), 1);
    idle(10);
    chk("false_start_busy_at_60", int'(busy), 0);
    chk("false_start_pulses", (n_valid - v0) + (n_ferr - f0), 0);
    chk("false_start_elapsed", cyc - t, 60);

    // Stop bit low, then break for 2000 cycles
    v0 = n_valid; f0 = n_ferr;
    tx(8'h3C, 1'b0, 1'b0);
    idle(2000);
    chk("break_busy_held", int'(busy), 1);
    rxd = 1'b1;
    idle(5);
    chk("break_busy_released", int'(busy), 0);
    chk("break_ferr_count", n_ferr - f0, 1);
    chk("break_valid_count", n_valid - v0, 0);
    chk("break_data_out_kept", int'(data_out), 8'h80);

    // Reset at data bit 4 of 0x5A, then clean 0x81
    v0 = n_valid; f0 = n_ferr;
    ab = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(ab[i]);
    reset = 1'b0;
    rxd   = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(20);
    chk("abort_data_out", int'(data_out), 8'h00);
    chk("abort_busy", int'(busy), 0);
    chk("abort_pulses", (n_valid - v0) + (n_ferr - f0), 0);
    tx(8'h81, 1'b1, 1'b0);
    idle(20);
    chk("after_abort_valid_count", n_valid - v0, 1);
    chk("after_abort_data_out", int'(data_out), 8'h81);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even-parity bit must be 1
    v0 = n_valid; p0 = n_perr;
    tx(8'h07, 1'b1, 1'b1);
    idle(20);
    chk("bad_parity_perr_count", n_perr - p0, 1);
    chk("bad_parity_valid_count", n_valid - v0, 0);
    chk("bad_parity_data_out", int'(data_out), 8'h81);
    v0 = n_valid; p0 = n_perr;
    tx(8'h07, 1'b1, 1'b0);
    idle(20);
    chk("good_parity_valid_count", n_valid - v0, 1);
    chk("good_parity_perr_count", n_perr - p0, 0);
    chk("good_parity_data_out", int'(data_out), 8'h07);
`else
    p0 = n_perr;
    chk("no_parity_events", n_perr - p0, 0);
`endif

    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
